// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit.
// Width codes, FSM states and size helpers.
package load_store_unit_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIRST,
      S_SECOND,
      S_LAST_READ,
      S_RESPOND
   } lsu_state_t;

   function automatic logic [2:0] f3_size(input logic [2:0] f3);
      logic [2:0] s;
      case (f3)
         F3_B, F3_BU: s = 3'd1;
         F3_H, F3_HU: s = 3'd2;
         default:     s = 3'd4;
      endcase
      return s;
   endfunction

   function automatic logic f3_illegal(input logic wr,
                                       input logic [2:0] f3);
      logic bad;
      if (wr)
         bad = (f3 > F3_W);
      else
         bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: enables, store rotation,
// load extraction and sign/zero extension.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] word0,
   input  logic [23:0] word1,
   output logic [3:0]  be_first,
   output logic [3:0]  be_second,
   output logic        split,
   output logic [31:0] wdata_rot,
   output logic [31:0] rdata
);

   logic [7:0]  base;
   logic [7:0]  mask;
   logic [31:0] low;

   // Lane mask over two words; upper nibble is the spill-over
   always_comb begin
      case (f3_size(funct3))
         3'd1:    base = 8'h01;
         3'd2:    base = 8'h03;
         default: base = 8'h0F;
      endcase
      mask      = base << off;
      be_first  = mask[3:0];
      be_second = mask[7:4];
      split     = |mask[7:4];
   end

   always_comb begin
      case (off)
         2'd0:    wdata_rot = wdata;
         2'd1:    wdata_rot = {wdata[23:0], wdata[31:24]};
         2'd2:    wdata_rot = {wdata[15:0], wdata[31:16]};
         default: wdata_rot = {wdata[7:0], wdata[31:8]};
      endcase
   end

   always_comb begin
      case (off)
         2'd0:    low = word0;
         2'd1:    low = {word1[7:0], word0[31:8]};
         2'd2:    low = {word1[15:0], word0[31:16]};
         default: low = {word1[23:0], word0[31:24]};
      endcase
   end

   always_comb begin
      case (funct3)
         F3_B:    rdata = {{24{low[7]}}, low[7:0]};
         F3_H:    rdata = {{16{low[15]}}, low[15:0]};
         F3_W:    rdata = low;
         F3_BU:   rdata = {24'd0, low[7:0]};
         F3_HU:   rdata = {16'd0, low[15:0]};
         default: rdata = 32'd0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: misaligned accesses
// split into two word transfers on a sync bus.
`ifndef DATA_BEGIN
`define DATA_BEGIN 32'h0000_1000
`endif
`ifndef DATA_END
`define DATA_END 32'h0000_1FFF
`endif

module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter logic [31:0] DATA_BEGIN = `DATA_BEGIN,
   parameter logic [31:0] DATA_END   = `DATA_END
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_address,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] bus_address,
   output logic [31:0] bus_write_data,
   output logic [3:0]  bus_byte_enable,
   output logic        bus_read_enable,
   output logic        bus_write_enable,
   input  logic [31:0] bus_read_data
);

   lsu_state_t  state;
   logic [1:0]  off_q;
   logic [2:0]  funct3_q;
   logic        write_q;
   logic        split_q;
   logic [3:0]  be_second_q;
   logic [31:0] word0_q;

   logic        idle;
   logic [1:0]  al_off;
   logic [2:0]  al_f3;
   logic [31:0] al_word0;
   logic [23:0] al_word1;
   logic [3:0]  al_be_first;
   logic [3:0]  al_be_second;
   logic        al_split;
   logic [31:0] al_wdata_rot;
   logic [31:0] al_rdata;

   logic [32:0] last_byte;
   logic        req_err;

   // Lane logic sees the live request in IDLE, the latched one after
   assign idle     = (state == S_IDLE);
   assign al_off   = idle ? req_address[1:0] : off_q;
   assign al_f3    = idle ? req_funct3 : funct3_q;
   assign al_word0 = split_q ? word0_q : bus_read_data;
   assign al_word1 = split_q ? bus_read_data[23:0] : 24'd0;

   lsu_align u_align (
      .off       (al_off),
      .funct3    (al_f3),
      .wdata     (req_wdata),
      .word0     (al_word0),
      .word1     (al_word1),
      .be_first  (al_be_first),
      .be_second (al_be_second),
      .split     (al_split),
      .wdata_rot (al_wdata_rot),
      .rdata     (al_rdata)
   );

   // 33-bit end address so a wrap past 0xFFFFFFFF always fails
   assign last_byte = {1'b0, req_address}
                    + {30'd0, f3_size(req_funct3)} - 33'd1;
   assign req_err   = f3_illegal(req_write, req_funct3)
                    || (req_address < DATA_BEGIN)
                    || (last_byte > {1'b0, DATA_END});

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         req_ready        <= 1'b0;
         resp_valid       <= 1'b0;
         resp_rdata       <= 32'd0;
         resp_error       <= 1'b0;
         bus_address      <= 32'd0;
         bus_write_data   <= 32'd0;
         bus_byte_enable  <= 4'd0;
         bus_read_enable  <= 1'b0;
         bus_write_enable <= 1'b0;
         off_q            <= 2'd0;
         funct3_q         <= 3'd0;
         write_q          <= 1'b0;
         split_q          <= 1'b0;
         be_second_q      <= 4'd0;
         word0_q          <= 32'd0;
      end else begin
         req_ready        <= 1'b0;
         resp_valid       <= 1'b0;
         resp_rdata       <= 32'd0;
         resp_error       <= 1'b0;
         bus_address      <= 32'd0;
         bus_write_data   <= 32'd0;
         bus_byte_enable  <= 4'd0;
         bus_read_enable  <= 1'b0;
         bus_write_enable <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  off_q       <= req_address[1:0];
                  funct3_q    <= req_funct3;
                  write_q     <= req_write;
                  split_q     <= al_split;
                  be_second_q <= al_be_second;
                  if (req_err) begin
                     state      <= S_RESPOND;
                     resp_valid <= 1'b1;
                     resp_error <= 1'b1;
                  end else begin
                     state            <= S_FIRST;
                     bus_address      <= {req_address[31:2], 2'b00};
                     bus_byte_enable  <= al_be_first;
                     bus_write_data   <= al_wdata_rot;
                     bus_write_enable <= req_write;
                     bus_read_enable  <= !req_write;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            S_FIRST: begin
               if (split_q) begin
                  state            <= S_SECOND;
                  bus_address      <= bus_address + 32'd4;
                  bus_byte_enable  <= be_second_q;
                  bus_write_data   <= bus_write_data;
                  bus_write_enable <= write_q;
                  bus_read_enable  <= !write_q;
               end else if (write_q) begin
                  state      <= S_RESPOND;
                  resp_valid <= 1'b1;
               end else begin
                  state <= S_LAST_READ;
               end
            end
            S_SECOND: begin
               word0_q <= bus_read_data;
               if (write_q) begin
                  state      <= S_RESPOND;
                  resp_valid <= 1'b1;
               end else begin
                  state <= S_LAST_READ;
               end
            end
            S_LAST_READ: begin
               state      <= S_RESPOND;
               resp_valid <= 1'b1;
               resp_rdata <= al_rdata;
            end
            S_RESPOND: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed
// requests, bus and response monitors.
module tb_load_store_unit;

   localparam logic [31:0] DB = 32'h0000_1000;
   localparam logic [31:0] DE = 32'h0000_1FFF;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_address = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [31:0] bus_address;
   logic [31:0] bus_write_data;
   logic [3:0]  bus_byte_enable;
   logic        bus_read_enable;
   logic        bus_write_enable;
   logic [31:0] bus_read_data = 32'd0;

   always #5 clock = ~clock;

   load_store_unit #(.DATA_BEGIN(DB), .DATA_END(DE)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_funct3       (req_funct3),
      .req_address      (req_address),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .resp_error       (resp_error),
      .bus_address      (bus_address),
      .bus_write_data   (bus_write_data),
      .bus_byte_enable  (bus_byte_enable),
      .bus_read_enable  (bus_read_enable),
      .bus_write_enable (bus_write_enable),
      .bus_read_data    (bus_read_data)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endfunction

   // Synchronous word memory covering the legal data window
   logic [31:0] mem [1024];

   always @(posedge clock) begin
      if (bus_write_enable)
         for (int i = 0; i < 4; i++)
            if (bus_byte_enable[i])
               mem[bus_address[11:2]][8*i +: 8] <= bus_write_data[8*i +: 8];
      if (bus_read_enable)
         bus_read_data <= mem[bus_address[11:2]];
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      string       nm;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
      logic        we;
   } bus_t;

   rsp_t rq[$];
   bus_t bq[$];

   always @(negedge clock) begin
      if (reset_n) begin
         if (resp_valid) begin
            if (rq.size() == 0) begin
               chk("unexpected resp", {31'd0, resp_valid}, 32'd0);
            end else begin
               rsp_t r;
               r = rq.pop_front();
               chk({r.nm, " rdata"}, resp_rdata, r.rdata);
               chk({r.nm, " error"}, {31'd0, resp_error}, {31'd0, r.err});
               chk({r.nm, " cycle"}, cyc, r.cyc);
            end
         end
         if (bus_read_enable || bus_write_enable) begin
            if (bq.size() == 0) begin
               chk("unexpected strobe", {30'd0, bus_read_enable,
                   bus_write_enable}, 32'd0);
            end else begin
               bus_t b;
               b = bq.pop_front();
               chk("bus addr", bus_address, b.addr);
               chk("bus be", {28'd0, bus_byte_enable}, {28'd0, b.be});
               chk("bus data", bus_write_data, b.data);
               chk("bus strobes", {30'd0, bus_read_enable,
                   bus_write_enable}, {30'd0, !b.we, b.we});
            end
         end else begin
            chk("bus idle zero", bus_address | bus_write_data
                | {28'd0, bus_byte_enable}, 32'd0);
         end
      end
   end

   task automatic bx(input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] d, input logic we);
      bus_t b;
      b.addr = a;
      b.be   = be;
      b.data = d;
      b.we   = we;
      bq.push_back(b);
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      @(negedge clock);
      while (!req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) chk({nm, " ready timeout"}, 32'd0, 32'd1);
   endtask

   task automatic issue(input string nm, input logic w,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input logic err, input int lat);
      rsp_t r;
      wait_ready(nm);
      req_valid   = 1'b1;
      req_write   = w;
      req_funct3  = f3;
      req_address = a;
      req_wdata   = wd;
      @(posedge clock);
      #1;
      r.rdata = rd;
      r.err   = err;
      r.cyc   = cyc + lat - 1;
      r.nm    = nm;
      rq.push_back(r);
      req_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("reset ready", {31'd0, req_ready}, 32'd0);
      chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("reset strobes", {30'd0, bus_read_enable,
          bus_write_enable}, 32'd0);
      chk("reset bus addr", bus_address, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("ready after release", {31'd0, req_ready}, 32'd1);

      // Aligned and split stores
      bx(32'h1014, 4'hF, 32'h0, 1);
      issue("sw zero", 1, 3'd2, 32'h1014, 32'h0, 32'h0, 0, 2);
      bx(32'h1010, 4'hF, 32'h11223344, 1);
      issue("sw", 1, 3'd2, 32'h1010, 32'h11223344, 32'h0, 0, 2);
      bx(32'h1010, 4'h8, 32'hEF0000BE, 1);
      bx(32'h1014, 4'h1, 32'hEF0000BE, 1);
      issue("sh split", 1, 3'd1, 32'h1013, 32'h0000BEEF, 32'h0, 0, 3);

      // Byte loads with sign and zero extension
      bx(32'h1020, 4'hF, 32'h00008000, 1);
      issue("sw 8000", 1, 3'd2, 32'h1020, 32'h00008000, 32'h0, 0, 2);
      bx(32'h1020, 4'h2, 32'h0, 0);
      issue("lb", 0, 3'd0, 32'h1021, 32'h0, 32'hFFFFFF80, 0, 3);
      bx(32'h1020, 4'h2, 32'h0, 0);
      issue("lbu", 0, 3'd4, 32'h1021, 32'h0, 32'h00000080, 0, 3);

      // Split word load
      bx(32'h1030, 4'hF, 32'hAABBCCDD, 1);
      issue("sw w0", 1, 3'd2, 32'h1030, 32'hAABBCCDD, 32'h0, 0, 2);
      bx(32'h1034, 4'hF, 32'h11223344, 1);
      issue("sw w1", 1, 3'd2, 32'h1034, 32'h11223344, 32'h0, 0, 2);
      bx(32'h1030, 4'hC, 32'h0, 0);
      bx(32'h1034, 4'h3, 32'h0, 0);
      issue("lw split", 0, 3'd2, 32'h1032, 32'h0, 32'h3344AABB, 0, 4);

      // Read back what the split store wrote
      bx(32'h1010, 4'h8, 32'h0, 0);
      bx(32'h1014, 4'h1, 32'h0, 0);
      issue("lhu split", 0, 3'd5, 32'h1013, 32'h0, 32'h0000BEEF, 0, 4);
      bx(32'h1010, 4'h8, 32'h0, 0);
      bx(32'h1014, 4'h1, 32'h0, 0);
      issue("lh split", 0, 3'd1, 32'h1013, 32'h0, 32'hFFFFBEEF, 0, 4);
      bx(32'h1010, 4'hF, 32'h0, 0);
      issue("lw", 0, 3'd2, 32'h1010, 32'h0, 32'hEF223344, 0, 3);
      bx(32'h1014, 4'hF, 32'h0, 0);
      issue("lw upper", 0, 3'd2, 32'h1014, 32'h0, 32'h000000BE, 0, 3);

      // Last legal byte
      bx(32'h1FFC, 4'h8, 32'hA5000000, 1);
      issue("sb end", 1, 3'd0, 32'h1FFF, 32'h000000A5, 32'h0, 0, 2);
      bx(32'h1FFC, 4'h8, 32'h0, 0);
      issue("lbu end", 0, 3'd4, 32'h1FFF, 32'h0, 32'h000000A5, 0, 3);

      // Rejected requests
      issue("lw past end", 0, 3'd2, 32'h1FFE, 32'h0, 32'h0, 1, 1);
      issue("lh past end", 0, 3'd1, 32'h1FFF, 32'h0, 32'h0, 1, 1);
      issue("load f3=3", 0, 3'd3, 32'h1040, 32'h0, 32'h0, 1, 1);
      issue("load f3=6", 0, 3'd6, 32'h1040, 32'h0, 32'h0, 1, 1);
      issue("store f3=4", 1, 3'd4, 32'h1040, 32'h12345678, 32'h0, 1, 1);
      issue("lb below", 0, 3'd0, 32'h0FFF, 32'h0, 32'h0, 1, 1);
      issue("lw wrap", 0, 3'd2, 32'hFFFFFFFE, 32'h0, 32'h0, 1, 1);

      // Reset during the second half of a split store
      bx(32'h1050, 4'hF, 32'h0, 1);
      issue("sw clr0", 1, 3'd2, 32'h1050, 32'h0, 32'h0, 0, 2);
      bx(32'h1054, 4'hF, 32'h0, 1);
      issue("sw clr1", 1, 3'd2, 32'h1054, 32'h0, 32'h0, 0, 2);
      bx(32'h1050, 4'h8, 32'hEF0000BE, 1);
      wait_ready("abort sh");
      req_valid   = 1'b1;
      req_write   = 1'b1;
      req_funct3  = 3'd1;
      req_address = 32'h1053;
      req_wdata   = 32'h0000BEEF;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      chk("abort second we", {31'd0, bus_write_enable}, 32'd1);
      chk("abort second be", {28'd0, bus_byte_enable}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort we drop", {31'd0, bus_write_enable}, 32'd0);
      chk("abort be drop", {28'd0, bus_byte_enable}, 32'd0);
      chk("abort ready low", {31'd0, req_ready}, 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("abort ready back", {31'd0, req_ready}, 32'd1);
      bx(32'h1054, 4'hF, 32'h0, 0);
      issue("lw no second", 0, 3'd2, 32'h1054, 32'h0, 32'h0, 0, 3);
      bx(32'h1050, 4'hF, 32'h0, 0);
      issue("lw first kept", 0, 3'd2, 32'h1050, 32'h0, 32'hEF000000, 0, 3);

      begin
         int n = 0;
         while ((rq.size() != 0 || bq.size() != 0) && n < 100) begin
            @(negedge clock);
            n++;
         end
      end
      repeat (3) @(negedge clock);
      chk("resp queue drained", rq.size(), 32'd0);
      chk("bus queue drained", bq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
